// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: operand forwarding into the register, load-use hazard detection.
// Build macro ID_EX_FWD_EN enables MEM/WB forwarding; undefined, any RAW dependence stalls.
module id_ex_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_shamt,
    input  logic [3:0]  id_alu_op,
    input  logic        id_alu_src_imm,
    input  logic        id_shift_imm,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic [4:0]  mem_rd,
    input  logic [4:0]  wb_rd,
    input  logic        mem_reg_write,
    input  logic        wb_reg_write,
    input  logic [31:0] mem_result,
    input  logic [31:0] wb_result,
    output logic [31:0] ex_src_a,
    output logic [31:0] ex_src_b,
    output logic [31:0] ex_store_data,
    output logic [3:0]  ex_alu_op,
    output logic [4:0]  ex_rd,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        hazard_stall
);

    logic [31:0] src_a_q, src_a_d;
    logic [31:0] src_b_q, src_b_d;
    logic [31:0] store_data_q, store_data_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic [4:0]  rd_q, rd_d;
    logic        valid_q, valid_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;

    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;
    logic        hazard;
    logic        load_bubble;
    logic        load_new;

`ifdef ID_EX_FWD_EN
    // MEM is the younger producer, so it wins over WB when both match.
    always_comb begin
        fwd_rs = id_rs_data;
        fwd_rt = id_rt_data;
        if (mem_reg_write && (mem_rd == id_rs) && (id_rs != 5'd0)) begin
            fwd_rs = mem_result;
        end else if (wb_reg_write && (wb_rd == id_rs) && (id_rs != 5'd0)) begin
            fwd_rs = wb_result;
        end
        if (mem_reg_write && (mem_rd == id_rt) && (id_rt != 5'd0)) begin
            fwd_rt = mem_result;
        end else if (wb_reg_write && (wb_rd == id_rt) && (id_rt != 5'd0)) begin
            fwd_rt = wb_result;
        end
    end

    always_comb begin
        hazard = valid_q && mem_read_q && (rd_q != 5'd0) && id_valid &&
                 ((rd_q == id_rs) || (rd_q == id_rt));
    end
`else
    logic ex_raw;
    logic mem_raw;
    logic unused_fwd;

    assign unused_fwd = ^{wb_rd, wb_reg_write, wb_result, mem_result};

    // Without forwarding every in-flight producer must drain before the consumer enters EX.
    always_comb begin
        fwd_rs  = id_rs_data;
        fwd_rt  = id_rt_data;
        ex_raw  = valid_q && reg_write_q && (rd_q != 5'd0) &&
                  ((rd_q == id_rs) || (rd_q == id_rt));
        mem_raw = mem_reg_write && (mem_rd != 5'd0) &&
                  ((mem_rd == id_rs) || (mem_rd == id_rt));
        hazard  = id_valid && (ex_raw || mem_raw);
    end
`endif

    assign load_bubble = flush || (!stall && hazard);
    assign load_new    = !flush && !stall && !hazard;

    // Priority: flush, then stall (hold), then hazard bubble, then normal load.
    always_comb begin
        src_a_d      = src_a_q;
        src_b_d      = src_b_q;
        store_data_d = store_data_q;
        alu_op_d     = alu_op_q;
        rd_d         = rd_q;
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        if (load_bubble) begin
            src_a_d      = 32'd0;
            src_b_d      = 32'd0;
            store_data_d = 32'd0;
            alu_op_d     = 4'd0;
            rd_d         = 5'd0;
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
        end else if (load_new) begin
            src_a_d      = id_shift_imm ? {27'd0, id_shamt} : fwd_rs;
            src_b_d      = id_alu_src_imm ? id_imm : fwd_rt;
            store_data_d = fwd_rt;
            alu_op_d     = id_alu_op;
            rd_d         = id_rd;
            valid_d      = id_valid;
            reg_write_d  = id_valid && id_reg_write;
            mem_read_d   = id_valid && id_mem_read;
            mem_write_d  = id_valid && id_mem_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_a_q      <= 32'd0;
            src_b_q      <= 32'd0;
            store_data_q <= 32'd0;
            alu_op_q     <= 4'd0;
            rd_q         <= 5'd0;
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            src_a_q      <= src_a_d;
            src_b_q      <= src_b_d;
            store_data_q <= store_data_d;
            alu_op_q     <= alu_op_d;
            rd_q         <= rd_d;
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
        end
    end

    assign ex_src_a      = src_a_q;
    assign ex_src_b      = src_b_q;
    assign ex_store_data = store_data_q;
    assign ex_alu_op     = alu_op_q;
    assign ex_rd         = rd_q;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign hazard_stall  = hazard;

endmodule
